// File: rtl/alu_result_checker_if.sv
// Bundle of the issue tap, ALU outputs and checker results for alu_result_checker.
// Latency: none; signal container only.
// Backpressure: none; the checker observes the ALU stream and never stalls it.
interface alu_result_checker_if #(
  parameter int W   = 32,
  parameter int SHW = 5,
  parameter int CW  = 16
);
  // Control and issue-side tap
  logic           clear;
  logic           issue_valid;
  logic [3:0]     issue_opcode;
  logic [W-1:0]   issue_a;
  logic [W-1:0]   issue_b;
  logic [SHW-1:0] issue_shamt;

  // ALU outputs under check
  logic [W-1:0]   dut_result;
  logic           dut_carry;

  // Checker results
  logic           chk_valid;
  logic           chk_pass;
  logic           err_sticky;
  logic [CW-1:0]  chk_count;
  logic [CW-1:0]  err_count;
  logic [3:0]     first_err_opcode;
  logic [W-1:0]   first_err_expected;
  logic [W-1:0]   first_err_actual;

  // Harness side: drives the ALU tap and reads the verdicts
  modport master (
    output clear, issue_valid, issue_opcode, issue_a, issue_b, issue_shamt,
    output dut_result, dut_carry,
    input  chk_valid, chk_pass, err_sticky, chk_count, err_count,
    input  first_err_opcode, first_err_expected, first_err_actual
  );

  // Checker side
  modport slave (
    input  clear, issue_valid, issue_opcode, issue_a, issue_b, issue_shamt,
    input  dut_result, dut_carry,
    output chk_valid, chk_pass, err_sticky, chk_count, err_count,
    output first_err_opcode, first_err_expected, first_err_actual
  );
endinterface

// File: rtl/alu_result_checker.sv
// Scoreboard for the two-stage ALU: delays issued ops, recomputes result/carry, counts and captures mismatches.
// Latency: comparison registered LATENCY edges after the op is sampled at the ALU inputs.
// Backpressure: none; one comparison per cycle, bubbles pass through uncompared.
module alu_result_checker #(
  parameter int W       = 32,
  parameter int SHW     = 5,
  parameter int LATENCY = 2,
  parameter int CW      = 16
) (
  input logic             clk,
  input logic             rst,
  alu_result_checker_if.slave bus
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_SRA = 4'd3;
  localparam logic [3:0] OP_NOR = 4'd4;

  typedef struct packed {
    logic           valid;
    logic [3:0]     opcode;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [SHW-1:0] shamt;
  } stage_t;

  // Delay line; the last stage lines up with the ALU output in the same cycle.
  stage_t pipe [LATENCY];
  stage_t head;

  logic [W:0]   sum_w;
  logic [W:0]   diff_w;
  logic [W-1:0] exp_res;
  logic         exp_carry;
  logic         carry_cmp;
  logic         match;
  logic         mismatch;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  assign head = pipe[LATENCY-1];

  // Shift the issued operation down the delay line; reset drops everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{valid:  bus.issue_valid,
                   opcode: bus.issue_opcode,
                   a:      bus.issue_a,
                   b:      bus.issue_b,
                   shamt:  bus.issue_shamt};
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Reference model of the ALU for the operation currently at the head.
  always_comb begin
    sum_w     = {1'b0, head.a} + {1'b0, head.b};
    // Bit W of the zero-extended difference is the unsigned borrow (a < b).
    diff_w    = {1'b0, head.a} - {1'b0, head.b};
    exp_res   = '0;
    exp_carry = 1'b0;
    carry_cmp = 1'b0;
    case (head.opcode)
      OP_ADD: begin
        exp_res   = sum_w[W-1:0];
        exp_carry = sum_w[W];
        carry_cmp = 1'b1;
      end
      OP_SUB: begin
        exp_res   = diff_w[W-1:0];
        exp_carry = diff_w[W];
        carry_cmp = 1'b1;
      end
      OP_MUL:  exp_res = head.a * head.b;
      OP_SRA:  exp_res = $unsigned($signed(head.a) >>> head.shamt);
      OP_NOR:  exp_res = ~(head.a | head.b);
      default: exp_res = '0;
    endcase
  end

  // Carry only matters for ADD/SUB; elsewhere the ALU just holds its old flag.
  always_comb begin
    match    = (bus.dut_result == exp_res) &&
               (!carry_cmp || (bus.dut_carry == exp_carry));
    mismatch = head.valid && !match;
  end

  // Per-comparison verdict pulse; clear does not suppress it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.chk_valid <= 1'b0;
      bus.chk_pass  <= 1'b0;
    end else begin
      bus.chk_valid <= head.valid;
      bus.chk_pass  <= head.valid && match;
    end
  end

  // Saturating counters and sticky error flag; clear wins over a landing comparison.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.chk_count  <= '0;
      bus.err_count  <= '0;
      bus.err_sticky <= 1'b0;
    end else if (bus.clear) begin
      bus.chk_count  <= '0;
      bus.err_count  <= '0;
      bus.err_sticky <= 1'b0;
    end else if (head.valid) begin
      bus.chk_count <= sat_inc(bus.chk_count);
      if (mismatch) begin
        bus.err_count  <= sat_inc(bus.err_count);
        bus.err_sticky <= 1'b1;
      end
    end
  end

  // Snapshot of the first mismatch since reset/clear; later ones leave it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.first_err_opcode   <= '0;
      bus.first_err_expected <= '0;
      bus.first_err_actual   <= '0;
    end else if (bus.clear) begin
      bus.first_err_opcode   <= '0;
      bus.first_err_expected <= '0;
      bus.first_err_actual   <= '0;
    end else if (mismatch && !bus.err_sticky) begin
      bus.first_err_opcode   <= head.opcode;
      bus.first_err_expected <= exp_res;
      bus.first_err_actual   <= bus.dut_result;
    end
  end

endmodule
